// File: rtl/pixel_shader_pipe.sv
// pixel_shader_pipe: 3-stage procedural RGB888 shader (radial ring + XOR texture) on an AXI4-Stream output.
// Optional CROSSHAIR_EN forces white on the x==0 / y==0 axes.
module pixel_shader_pipe #(
    parameter int RING_SHIFT = 4
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic signed [15:0] s_x,
    input  logic signed [15:0] s_y,
    input  logic               s_first,
    input  logic               s_lastx,
    input  logic               s_valid,
    output logic               s_ready,
    output logic        [23:0] m_tdata,
    output logic               m_tuser,
    output logic               m_tlast,
    output logic               m_tvalid,
    input  logic               m_tready
);
    typedef struct packed {
        logic        v;
        logic [31:0] sqx;
        logic [31:0] sqy;
        logic [7:0]  b;
        logic [7:0]  ph;
        logic        first;
        logic        last;
`ifdef CROSSHAIR_EN
        logic        cross;
`endif
    } s1_t;

    typedef struct packed {
        logic        v;
        logic [31:0] r2;
        logic [7:0]  b;
        logic [7:0]  ph;
        logic        first;
        logic        last;
`ifdef CROSSHAIR_EN
        logic        cross;
`endif
    } s2_t;

    typedef struct packed {
        logic        v;
        logic [23:0] data;
        logic        user;
        logic        last;
    } s3_t;

    s1_t s1_q, s1_d;
    s2_t s2_q, s2_d;
    s3_t s3_q, s3_d;
    logic [7:0] phase_q, phase_d;
    logic adv1, adv2, adv3;
    logic signed [31:0] xs, ys;
    logic [7:0] ring;

    always_comb begin
        adv3 = m_tready || !s3_q.v;
        adv2 = adv3 || !s2_q.v;
        adv1 = adv2 || !s1_q.v;
        s_ready = adv1 && resetn;
        xs = {{16{s_x[15]}}, s_x};
        ys = {{16{s_y[15]}}, s_y};
        // A frame-start beat already sees the incremented phase.
        phase_d = phase_q + 8'(s_valid && s_ready && s_first);
        s1_d = s1_q;
        if (adv1) begin
            s1_d.v     = s_valid;
            s1_d.sqx   = xs * xs;
            s1_d.sqy   = ys * ys;
            s1_d.b     = s_x[7:0] ^ s_y[7:0];
            s1_d.ph    = phase_d;
            s1_d.first = s_first;
            s1_d.last  = s_lastx;
`ifdef CROSSHAIR_EN
            s1_d.cross = (s_x == 16'sd0) || (s_y == 16'sd0);
`endif
        end
        s2_d = s2_q;
        if (adv2) begin
            s2_d.v     = s1_q.v;
            s2_d.r2    = s1_q.sqx + s1_q.sqy;
            s2_d.b     = s1_q.b;
            s2_d.ph    = s1_q.ph;
            s2_d.first = s1_q.first;
            s2_d.last  = s1_q.last;
`ifdef CROSSHAIR_EN
            s2_d.cross = s1_q.cross;
`endif
        end
        ring = 8'(s2_q.r2 >> RING_SHIFT) + s2_q.ph;
        s3_d = s3_q;
        if (adv3) begin
            s3_d.v    = s2_q.v;
`ifdef CROSSHAIR_EN
            s3_d.data = s2_q.cross ? 24'hFFFFFF : {ring, ~ring, s2_q.b};
`else
            s3_d.data = {ring, ~ring, s2_q.b};
`endif
            s3_d.user = s2_q.first;
            s3_d.last = s2_q.last;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            s1_q    <= '0;
            s2_q    <= '0;
            s3_q    <= '0;
            phase_q <= '0;
        end else begin
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            s3_q    <= s3_d;
            phase_q <= phase_d;
        end
    end

    assign m_tvalid = s3_q.v;
    assign m_tdata  = s3_q.data;
    assign m_tuser  = s3_q.user;
    assign m_tlast  = s3_q.last;
endmodule

// File: tb/tb_pixel_shader_pipe.sv
// tb_pixel_shader_pipe: scoreboard bench for pixel_shader_pipe; directed corner beats plus randomized
// traffic with random backpressure, checked against an arithmetic colour model.
module tb_pixel_shader_pipe;
    localparam int RS = 4;

    logic               clk = 0;
    logic               resetn = 0;
    logic signed [15:0] s_x = 0;
    logic signed [15:0] s_y = 0;
    logic               s_first = 0;
    logic               s_lastx = 0;
    logic               s_valid = 0;
    logic               s_ready;
    logic        [23:0] m_tdata;
    logic               m_tuser;
    logic               m_tlast;
    logic               m_tvalid;
    logic               m_tready = 1;

    pixel_shader_pipe dut (
        .clk(clk), .resetn(resetn), .s_x(s_x), .s_y(s_y), .s_first(s_first), .s_lastx(s_lastx),
        .s_valid(s_valid), .s_ready(s_ready), .m_tdata(m_tdata), .m_tuser(m_tuser),
        .m_tlast(m_tlast), .m_tvalid(m_tvalid), .m_tready(m_tready)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int emitted = 0;
    int phase_m = 0;
    logic [25:0] exp_q[$];
    logic have_prev = 0;
    logic [25:0] prev = '0;
    logic saw_low = 0;
    logic done = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    // Colour straight from the arithmetic definition: ring from scaled radius squared, plus frame phase.
    function automatic logic [25:0] model(input int x, input int y, input logic f, input logic l, input int ph);
        longint r2 = longint'(x) * x + longint'(y) * y;
        logic [7:0] ring = 8'(((r2 / (64'sd1 << RS)) + ph) % 256);
        logic [23:0] d = {ring, 8'(255 - ring), 8'((x ^ y) & 255)};
`ifdef CROSSHAIR_EN
        if (x == 0 || y == 0) d = 24'hFFFFFF;
`endif
        return {d, f, l};
    endfunction

    always @(negedge clk) begin
        if (!resetn) begin
            exp_q.delete();
            phase_m = 0;
            have_prev = 0;
        end else begin
            if (have_prev && m_tvalid) chk("stall_stable", {6'b0, m_tdata, m_tuser, m_tlast}, {6'b0, prev});
            have_prev = m_tvalid && !m_tready;
            prev = {m_tdata, m_tuser, m_tlast};
            if (m_tvalid && m_tready) begin
                emitted++;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL beat_unexpected got=%h want=none", {m_tdata, m_tuser, m_tlast});
                end else begin
                    chk("beat", {6'b0, m_tdata, m_tuser, m_tlast}, {6'b0, exp_q.pop_front()});
                end
            end
            if (s_valid && s_ready) begin
                if (s_first) phase_m = (phase_m + 1) % 256;
                exp_q.push_back(model(int'(s_x), int'(s_y), s_first, s_lastx, phase_m));
            end
        end
    end

    task automatic send(input int x, input int y, input logic f, input logic l);
        int n = 0;
        s_x = 16'(x);
        s_y = 16'(y);
        s_first = f;
        s_lastx = l;
        s_valid = 1;
        forever begin
            @(negedge clk);
            if (s_ready) break;
            n++;
            if (n > 200) begin
                total++;
                bad++;
                $display("FAIL send_timeout got=no_accept want=accept");
                break;
            end
        end
        @(posedge clk);
        #1 s_valid = 0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!m_tvalid && n < 20);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 resetn = 0;
        @(posedge clk);
        #1 resetn = 1;
    endtask

    task automatic drain(input string nm);
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        chk(nm, exp_q.size(), 0);
    endtask

    task automatic directed(input string nm, input int x, input int y, input logic f, input logic l,
                            input logic [25:0] e);
        int n;
        do_reset();
        send(x, y, f, l);
        wait_valid(n);
        chk({nm, "_latency"}, n, 3);
        chk(nm, {6'b0, m_tdata, m_tuser, m_tlast}, {6'b0, e});
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout got=running want=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        logic signed [15:0] rx, ry;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_state", {4'b0, m_tvalid, m_tdata, m_tuser, m_tlast, s_ready}, 32'h0);
        @(posedge clk);
        #1 resetn = 1;

        directed("ring_basic", 3, 4, 0, 0, {24'h01FE07, 1'b0, 1'b0});
        directed("frame_first", 3, 4, 1, 0, {24'h02FD07, 1'b1, 1'b0});
        directed("neg_lastx", -1, -1, 0, 1, {24'h00FF00, 1'b0, 1'b1});
`ifdef CROSSHAIR_EN
        directed("origin", 0, 0, 0, 0, {24'hFFFFFF, 1'b0, 1'b0});
`else
        directed("origin", 0, 0, 0, 0, {24'h00FF00, 1'b0, 1'b0});
`endif

        do_reset();
        emitted = 0;
        saw_low = 0;
        fork
            for (int i = 0; i < 10; i++) begin
                rx = 16'($urandom);
                ry = 16'($urandom);
                send(rx, ry, i == 0, i == 9);
            end
            begin
                repeat (4) @(posedge clk);
                #1 m_tready = 0;
                repeat (5) begin
                    @(negedge clk);
                    if (!s_ready) saw_low = 1;
                end
                @(posedge clk);
                #1 m_tready = 1;
            end
        join
        drain("stall_drain");
        chk("stall_sready_low", saw_low, 1);
        chk("stall_count", emitted, 10);

        do_reset();
        m_tready = 0;
        for (int i = 0; i < 3; i++) send(10 + i, 20 + i, 0, 0);
        resetn = 0;
        @(negedge clk);
        @(negedge clk);
        chk("flush_tvalid", m_tvalid, 0);
        @(posedge clk);
        #1 resetn = 1;
        m_tready = 1;
        send(3, 4, 0, 0);
        wait_valid(n);
        chk("flush_latency", n, 3);
        chk("flush_beat", {8'b0, m_tdata}, {8'b0, 24'h01FE07});
        drain("flush_drain");

        do_reset();
        emitted = 0;
        done = 0;
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    repeat ($urandom_range(0, 2)) begin
                        @(posedge clk);
                        #1;
                    end
                    rx = ($urandom_range(0, 9) == 0) ? 16'sd0 : 16'($urandom);
                    ry = ($urandom_range(0, 9) == 0) ? 16'sd0 : 16'($urandom);
                    send(rx, ry, $urandom_range(0, 15) == 0, $urandom_range(0, 7) == 0);
                end
                done = 1;
            end
            while (!done) begin
                @(posedge clk);
                #1 m_tready = ($urandom_range(0, 3) != 0);
            end
        join
        m_tready = 1;
        drain("random_drain");
        chk("random_count", emitted, 300);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
